// File: rtl/pcie_vc_credit_scheduler_if.sv
// rtl/pcie_vc_credit_scheduler_if.sv - TLP output stream from the VC scheduler toward the DLL
interface pcie_vc_credit_scheduler_if #(
    parameter int TLP_W = 224
);
    logic             tlp_valid_o;
    logic             tlp_ready_i;
    logic [TLP_W-1:0] tlp_o;
    logic [2:0]       tlp_vc_o;

    modport master (
        output tlp_valid_o,
        output tlp_o,
        output tlp_vc_o,
        input  tlp_ready_i
    );

    modport slave (
        input  tlp_valid_o,
        input  tlp_o,
        input  tlp_vc_o,
        output tlp_ready_i
    );
endinterface

// File: rtl/pcie_vc_credit_scheduler.sv
// rtl/pcie_vc_credit_scheduler.sv - weighted round-robin TLP scheduler gated by per-VC flow-control credits
module pcie_vc_credit_scheduler #(
    parameter int NUM_VC  = 2,
    parameter int TLP_W   = 224,
    parameter int HDR_CW  = 8,
    parameter int DATA_CW = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_VC-1:0]         vc_empty,
    input  logic [NUM_VC*TLP_W-1:0]   vc_rdata,
    output logic [NUM_VC-1:0]         vc_rden,
    input  logic [NUM_VC*4-1:0]       cfg_weight,
    input  logic                      fc_upd_valid,
    input  logic [2:0]                fc_upd_vc,
    input  logic [HDR_CW-1:0]         fc_upd_hdr_lim,
    input  logic [DATA_CW-1:0]        fc_upd_data_lim,
    output logic [NUM_VC-1:0]         credit_blocked_o,
    pcie_vc_credit_scheduler_if.master tlp
);

    typedef enum logic {ARB, SEND} state_t;

    localparam logic [HDR_CW-1:0]  HDR_HALF  = HDR_CW'(1) << (HDR_CW - 1);
    localparam logic [DATA_CW-1:0] DATA_HALF = DATA_CW'(1) << (DATA_CW - 1);

    state_t             state;
    logic [HDR_CW-1:0]  hdr_lim   [NUM_VC];
    logic [HDR_CW-1:0]  hdr_cons  [NUM_VC];
    logic [HDR_CW-1:0]  hdr_diff  [NUM_VC];
    logic [DATA_CW-1:0] data_lim  [NUM_VC];
    logic [DATA_CW-1:0] data_cons [NUM_VC];
    logic [DATA_CW-1:0] data_req  [NUM_VC];
    logic [DATA_CW-1:0] data_diff [NUM_VC];
    logic [NUM_VC-1:0]  fc_init;
    logic [NUM_VC-1:0]  suff;
    // Padded to 8 entries so a 3-bit pointer can index them directly
    logic [7:0]         elig8;
    logic [3:0]         weight8 [8];
    logic [2:0]         rr_ptr;
    logic [2:0]         winner;
    logic [2:0]         idx;
    logic [3:0]         burst_cnt;
    logic [3:0]         burst_nxt;
    logic               found;
    logic               grant;

    function automatic logic [DATA_CW-1:0] data_credits(input logic [31:0] dw0);
        logic [10:0] lp3;
        lp3 = {1'b0, dw0[9:0]} + 11'd3;
        if (!dw0[30])
            return '0;
        if (dw0[9:0] == 10'd0)
            return DATA_CW'(256);
        return DATA_CW'(lp3[10:2]);
    endfunction

    // Modular compare keeps the check correct across counter wrap
    always_comb begin
        elig8 = '0;
        suff  = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            data_req[i]  = data_credits(vc_rdata[i*TLP_W +: 32]);
            hdr_diff[i]  = hdr_lim[i] - (hdr_cons[i] + HDR_CW'(1));
            data_diff[i] = data_lim[i] - (data_cons[i] + data_req[i]);
            suff[i]      = (hdr_diff[i] <= HDR_HALF) && (data_diff[i] <= DATA_HALF);
            elig8[i]     = !vc_empty[i] && fc_init[i] && suff[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++)
            weight8[i] = 4'd1;
        for (int i = 0; i < NUM_VC; i++)
            weight8[i] = (cfg_weight[i*4 +: 4] == 4'd0) ? 4'd1 : cfg_weight[i*4 +: 4];
    end

    always_comb begin
        winner    = rr_ptr;
        burst_nxt = 4'd1;
        found     = 1'b0;
        idx       = '0;
        if (elig8[rr_ptr] && (burst_cnt < weight8[rr_ptr])) begin
            burst_nxt = burst_cnt + 4'd1;
        end else begin
            for (int k = 1; k <= NUM_VC; k++) begin
                idx = 3'((int'(rr_ptr) + k) % NUM_VC);
                if (!found && elig8[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
        end
        grant   = !rst && (state == ARB) && (|elig8);
        vc_rden = '0;
        for (int i = 0; i < NUM_VC; i++)
            vc_rden[i] = grant && (winner == 3'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ARB;
            tlp.tlp_valid_o  <= 1'b0;
            tlp.tlp_o        <= '0;
            tlp.tlp_vc_o     <= '0;
            credit_blocked_o <= '0;
            rr_ptr           <= '0;
            burst_cnt        <= '0;
            fc_init          <= '0;
            for (int i = 0; i < NUM_VC; i++) begin
                hdr_lim[i]   <= '0;
                hdr_cons[i]  <= '0;
                data_lim[i]  <= '0;
                data_cons[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                credit_blocked_o[i] <= !vc_empty[i] && fc_init[i] && !suff[i];
                if (fc_upd_valid && (fc_upd_vc == 3'(i))) begin
                    hdr_lim[i]  <= fc_upd_hdr_lim;
                    data_lim[i] <= fc_upd_data_lim;
                    fc_init[i]  <= 1'b1;
                end
                if (vc_rden[i]) begin
                    hdr_cons[i]  <= hdr_cons[i] + HDR_CW'(1);
                    data_cons[i] <= data_cons[i] + data_req[i];
                    tlp.tlp_o    <= vc_rdata[i*TLP_W +: TLP_W];
                end
            end
            case (state)
                ARB: begin
                    if (grant) begin
                        state           <= SEND;
                        tlp.tlp_valid_o <= 1'b1;
                        tlp.tlp_vc_o    <= winner;
                        rr_ptr          <= winner;
                        burst_cnt       <= burst_nxt;
                    end
                end
                SEND: begin
                    if (tlp.tlp_ready_i) begin
                        state           <= ARB;
                        tlp.tlp_valid_o <= 1'b0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_vc_credit_scheduler.sv
// tb/tb_pcie_vc_credit_scheduler.sv - scoreboard bench for the VC credit scheduler
module tb_pcie_vc_credit_scheduler;

    localparam int NUM_VC = 2;
    localparam int TLP_W  = 224;

    typedef struct packed {
        logic [2:0]       vc;
        logic [TLP_W-1:0] tlp;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_VC-1:0]       vc_empty;
    logic [NUM_VC*TLP_W-1:0] vc_rdata;
    logic [NUM_VC-1:0]       vc_rden;
    logic [NUM_VC*4-1:0]     cfg_weight;
    logic                    fc_upd_valid;
    logic [2:0]              fc_upd_vc;
    logic [7:0]              fc_upd_hdr_lim;
    logic [11:0]             fc_upd_data_lim;
    logic [NUM_VC-1:0]       credit_blocked_o;

    pcie_vc_credit_scheduler_if #(.TLP_W(TLP_W)) bus ();

    pcie_vc_credit_scheduler #(
        .NUM_VC(NUM_VC), .TLP_W(TLP_W), .HDR_CW(8), .DATA_CW(12)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .vc_empty         (vc_empty),
        .vc_rdata         (vc_rdata),
        .vc_rden          (vc_rden),
        .cfg_weight       (cfg_weight),
        .fc_upd_valid     (fc_upd_valid),
        .fc_upd_vc        (fc_upd_vc),
        .fc_upd_hdr_lim   (fc_upd_hdr_lim),
        .fc_upd_data_lim  (fc_upd_data_lim),
        .credit_blocked_o (credit_blocked_o),
        .tlp              (bus.master)
    );

    always #5 clk = ~clk;

    logic [TLP_W-1:0]  fifo [NUM_VC][$];
    exp_t              exp_q [$];
    int                n_vec = 0;
    int                n_err = 0;
    logic [NUM_VC-1:0] rden_s;
    logic [NUM_VC-1:0] rden_seen;
    logic              valid_seen;
    logic [11:0]       dcons;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [TLP_W-1:0] mk(input logic [2:0] vc, input logic [7:0] tag,
                                            input logic hd, input logic [9:0] len);
        logic [TLP_W-1:0] t;
        t                 = '0;
        t[9:0]            = len;
        t[30]             = hd;
        t[63:32]          = {16'hA5C3, 5'd0, vc, tag};
        t[TLP_W-1 -: 8]   = tag ^ 8'h5A;
        return t;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NUM_VC; i++) begin
            vc_empty[i] = (fifo[i].size() == 0);
            vc_rdata[i*TLP_W +: TLP_W] = (fifo[i].size() == 0) ? '0 : fifo[i][0];
        end
    endtask

    task automatic step();
        @(negedge clk);
        rden_s    = vc_rden;
        rden_seen = rden_seen | vc_rden;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (rden_s[i]) begin
                if (fifo[i].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_empty vc=%0d actual=pop required=no_pop", i);
                end else begin
                    void'(fifo[i].pop_front());
                end
            end
        end
        refresh();
    endtask

    task automatic push(input int vc, input logic [TLP_W-1:0] t);
        fifo[vc].push_back(t);
        refresh();
    endtask

    task automatic push_exp(input logic [2:0] vc, input logic [TLP_W-1:0] t);
        exp_t e;
        e.vc  = vc;
        e.tlp = t;
        exp_q.push_back(e);
    endtask

    task automatic do_upd(input logic [2:0] vc, input logic [7:0] h, input logic [11:0] d);
        fc_upd_valid    = 1'b1;
        fc_upd_vc       = vc;
        fc_upd_hdr_lim  = h;
        fc_upd_data_lim = d;
        step();
        fc_upd_valid    = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            step();
            c++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NUM_VC; i++)
            fifo[i].delete();
        refresh();
    endtask

    // Scoreboard monitor: every accepted TLP must match the next expected entry
    always @(negedge clk) begin
        if (!rst && bus.tlp_valid_o && bus.tlp_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_tlp actual_vc=%0d actual_dw=%h required=none",
                         bus.tlp_vc_o, bus.tlp_o[63:0]);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                if (bus.tlp_vc_o !== e.vc || bus.tlp_o !== e.tlp) begin
                    n_err++;
                    $display("FAIL tlp_order actual_vc=%0d actual_dw=%h required_vc=%0d required_dw=%h",
                             bus.tlp_vc_o, bus.tlp_o[63:0], e.vc, e.tlp[63:0]);
                end
            end
        end
    end

    initial begin
        logic [TLP_W-1:0] ta;
        logic [TLP_W-1:0] tb;
        logic [TLP_W-1:0] t;
        int               c;

        rst             = 1'b1;
        vc_empty        = '1;
        vc_rdata        = '0;
        cfg_weight      = {4'd1, 4'd1};
        fc_upd_valid    = 1'b0;
        fc_upd_vc       = '0;
        fc_upd_hdr_lim  = '0;
        fc_upd_data_lim = '0;
        bus.tlp_ready_i = 1'b1;
        rden_seen       = '0;
        refresh();
        repeat (2) step();
        check("rst_valid", bus.tlp_valid_o, 0);
        check("rst_rden", vc_rden, 0);
        check("rst_blocked", credit_blocked_o, 0);
        check("rst_tlp", bus.tlp_o, 0);
        rst = 1'b0;

        // No UpdateFC yet: nothing may be granted
        push(0, mk(3'd0, 8'h10, 1'b0, 10'd0));
        push(1, mk(3'd1, 8'h11, 1'b0, 10'd0));
        rden_seen  = '0;
        valid_seen = 1'b0;
        repeat (20) begin
            step();
            valid_seen = valid_seen | bus.tlp_valid_o;
        end
        check("t1_no_rden", rden_seen, 0);
        check("t1_no_valid", valid_seen, 0);
        check("t1_not_blocked", credit_blocked_o, 0);
        clear_fifos();

        // Header limit 4 admits four MWr len=16, the fifth is starved
        for (int j = 0; j < 5; j++)
            push(0, mk(3'd0, 8'(8'h20 + j), 1'b1, 10'd16));
        for (int j = 0; j < 4; j++)
            push_exp(3'd0, mk(3'd0, 8'(8'h20 + j), 1'b1, 10'd16));
        do_upd(3'd0, 8'd4, 12'd64);
        check("t2_first_pop", vc_rden, 2'b01);
        step();
        check("t2_valid_latency", bus.tlp_valid_o, 1);
        check("t2_vc", bus.tlp_vc_o, 0);
        drain("t2_drain4", 40);
        rden_seen = '0;
        repeat (3) step();
        check("t2_blocked", credit_blocked_o, 2'b01);
        check("t2_no_pop", rden_seen, 0);
        check("t2_fifo_left", fifo[0].size(), 1);
        push_exp(3'd0, mk(3'd0, 8'h24, 1'b1, 10'd16));
        do_upd(3'd0, 8'd5, 12'd64);
        drain("t2_drain5", 10);

        // Weighted round robin 3:1
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_fifos();
        cfg_weight = {4'd1, 4'd3};
        do_upd(3'd0, 8'd100, 12'd0);
        do_upd(3'd1, 8'd100, 12'd0);
        for (int j = 0; j < 6; j++)
            fifo[0].push_back(mk(3'd0, 8'(8'h30 + j), 1'b0, 10'd0));
        for (int j = 0; j < 2; j++)
            fifo[1].push_back(mk(3'd1, 8'(8'h38 + j), 1'b0, 10'd0));
        for (int j = 0; j < 3; j++)
            push_exp(3'd0, mk(3'd0, 8'(8'h30 + j), 1'b0, 10'd0));
        push_exp(3'd1, mk(3'd1, 8'h38, 1'b0, 10'd0));
        for (int j = 3; j < 6; j++)
            push_exp(3'd0, mk(3'd0, 8'(8'h30 + j), 1'b0, 10'd0));
        push_exp(3'd1, mk(3'd1, 8'h39, 1'b0, 10'd0));
        refresh();
        drain("t3_wrr", 60);

        // Backpressure: SEND holds its TLP and no further pops occur
        bus.tlp_ready_i = 1'b0;
        ta = mk(3'd0, 8'h40, 1'b0, 10'd0);
        tb = mk(3'd1, 8'h41, 1'b0, 10'd0);
        push_exp(3'd0, ta);
        push_exp(3'd1, tb);
        push(0, ta);
        push(1, tb);
        step();
        rden_seen = '0;
        for (int j = 0; j < 5; j++) begin
            check("t4_valid", bus.tlp_valid_o, 1);
            check("t4_tlp_hold", bus.tlp_o, ta);
            check("t4_vc_hold", bus.tlp_vc_o, 0);
            step();
        end
        check("t4_no_rden", rden_seen, 0);
        bus.tlp_ready_i = 1'b1;
        drain("t4_drain", 20);

        // Data consumed walked up to 0xFFE, then wrap check
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_fifos();
        cfg_weight = {4'd1, 4'd1};
        dcons = 12'd0;
        for (int j = 0; j < 16; j++) begin
            do_upd(3'd0, 8'd100, dcons + 12'h400);
            t = mk(3'd0, 8'(8'h50 + j), 1'b1, (j < 15) ? 10'd0 : 10'd1016);
            push_exp(3'd0, t);
            push(0, t);
            drain("t5_walk", 10);
            dcons = dcons + ((j < 15) ? 12'd256 : 12'd254);
        end
        do_upd(3'd0, 8'd100, 12'h001);
        t = mk(3'd0, 8'h60, 1'b1, 10'd16);
        push(0, t);
        rden_seen = '0;
        repeat (4) step();
        check("t5_wrap_blocked", credit_blocked_o, 2'b01);
        check("t5_wrap_no_pop", rden_seen, 0);
        push_exp(3'd0, t);
        do_upd(3'd0, 8'd100, 12'h002);
        drain("t5_wrap_grant", 10);
        check("t5_fifo_empty", fifo[0].size(), 0);

        // Reset while a TLP sits in SEND
        bus.tlp_ready_i = 1'b0;
        push(0, mk(3'd0, 8'h70, 1'b0, 10'd0));
        c = 0;
        while (!bus.tlp_valid_o && c < 10) begin
            step();
            c++;
        end
        check("t6_in_send", bus.tlp_valid_o, 1);
        rst = 1'b1;
        push(0, mk(3'd0, 8'h71, 1'b0, 10'd0));
        step();
        check("t6_dropped", bus.tlp_valid_o, 0);
        check("t6_rden_in_rst", vc_rden, 0);
        rst = 1'b0;
        bus.tlp_ready_i = 1'b1;
        do_upd(3'd2, 8'd100, 12'd0);
        rden_seen  = '0;
        valid_seen = 1'b0;
        repeat (5) begin
            step();
            valid_seen = valid_seen | bus.tlp_valid_o;
        end
        check("t6_fc_reinit_no_rden", rden_seen, 0);
        check("t6_no_valid", valid_seen, 0);
        check("t6_not_blocked", credit_blocked_o, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
